spi_controller: RTL

SPI Mode 0 controller that serialises 16-bit register-write frames for the team's SPI peripheral and for the bench/FPGA harness that configures it.
- Frame, MSB first: bit15 = R/W flag (1 = write), bits14:8 = 7-bit address, bits7:0 = data.
- Parallel request/ready handshake in; SCLK, COPI and nCS out.
- Generates all SPI timing from clk.
- Optional CIPO readback for read frames.

---
 rtl/spi_controller.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/spi_controller.sv
// SPI Mode 0 controller: serialises {R/W, addr[6:0], data[7:0]} frames MSB first.
// Define SPI_CONTROLLER_READBACK_EN to capture CIPO during the data phase of read frames.
module spi_controller #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SCLK,
    output logic       COPI,
    output logic       nCS,
    input  logic       CIPO
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   shift_q, shift_d;
    logic          rw_q, rw_d;
    logic          ncs_q, ncs_d;
    logic          sclk_q, sclk_d;
    logic          copi_q, copi_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            rw_q    <= 1'b0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            rw_q    <= rw_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        rw_d    = rw_q;
        ncs_d   = ncs_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    shift_d = {req_write, req_addr, req_data};
                    rw_d    = req_write;
                    bit_d   = '0;
                    div_d   = '0;
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                    copi_d  = req_write;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                // bit_q counts falling edges; the low half after the 16th one closes the shift phase
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d  = 1'b0;
                        shift_d = {shift_q[14:0], 1'b0};
                        copi_d  = shift_q[14];
                        bit_d   = bit_q + 5'd1;
                    end else if (bit_q == 5'd16) begin
                        copi_d  = 1'b0;
                        state_d = HOLD;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    ncs_d   = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // ready is held low for the done cycle so it rises the cycle after done
        ready_d = (state_d == IDLE) && !done_d;
    end

    assign req_ready = ready_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign SCLK      = sclk_q;
    assign COPI      = copi_q;
    assign nCS       = ncs_q;

`ifdef SPI_CONTROLLER_READBACK_EN
    logic [7:0] cap_q;
    logic [7:0] rd_q;
    logic       rdv_q;
    logic       cap_en;

    // SCLK rising edges with 8..15 completed bits are the data-phase rises
    assign cap_en = (state_q == SHIFT) && !sclk_q && (div_q == DIV_LAST) &&
                    (bit_q >= 5'd8) && (bit_q != 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
            rd_q  <= '0;
            rdv_q <= 1'b0;
        end else begin
            rdv_q <= done_d && !rw_q;
            if (cap_en) begin
                cap_q <= {cap_q[6:0], CIPO};
            end
            if (done_d && !rw_q) begin
                rd_q <= cap_q;
            end
        end
    end

    assign rd_data  = rd_q;
    assign rd_valid = rdv_q;
`else
    logic unused_cipo;
    assign unused_cipo = CIPO;
    assign rd_data     = '0;
    assign rd_valid    = 1'b0;
`endif

endmodule
